// File: rtl/rt_stream_pkg.sv
// rtl/rt_stream_pkg.sv - shared ray-stream assembler state and packet word indices
package rt_stream_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } asm_state_e;

   localparam int RAY_OX = 0;
   localparam int RAY_OY = 1;
   localparam int RAY_OZ = 2;
   localparam int RAY_DX = 3;
   localparam int RAY_DY = 4;
   localparam int RAY_DZ = 5;

endpackage

// File: rtl/fifo_ray_assembler_if.sv
// rtl/fifo_ray_assembler_if.sv - FIFO read port and ray packet stream bundle
interface fifo_ray_assembler_if #(
   parameter int DATA_WIDTH = 32,
   parameter int WORDS      = 6,
   parameter int ID_WIDTH   = 16
);
   logic                        fifo_empty;
   logic [DATA_WIDTH-1:0]       fifo_data;
   logic                        fifo_r_en;
   logic                        flush;
   logic                        out_valid;
   logic                        out_ready;
   logic [WORDS*DATA_WIDTH-1:0] out_data;
   logic [ID_WIDTH-1:0]         out_id;
   logic                        busy;

   modport slave (
      input  fifo_empty, fifo_data, flush, out_ready,
      output fifo_r_en, out_valid, out_data, out_id, busy
   );

   modport master (
      output fifo_empty, fifo_data, flush, out_ready,
      input  fifo_r_en, out_valid, out_data, out_id, busy
   );
endinterface

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - single-entry valid/ready output register
module stream_out_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             ready_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // A load in the same cycle as an accept keeps valid high with the new data.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
endmodule

// File: rtl/fifo_ray_assembler.sv
// rtl/fifo_ray_assembler.sv - pops FIFO words and assembles WORDS-word ray packets
module fifo_ray_assembler
   import rt_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int WORDS      = 6,
   parameter int ID_WIDTH   = 16
) (
   input  logic                 rclk,
   input  logic                 rrst,
   fifo_ray_assembler_if.slave  bus
);
   localparam int                CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WORDS - 1);
   localparam int                PKT_W    = WORDS * DATA_WIDTH;

   asm_state_e                         state_q, state_d;
   logic [CNT_W-1:0]                   cnt_q, cnt_d;
   logic [WORDS-1:0][DATA_WIDTH-1:0]   asm_q, asm_d;
   logic [ID_WIDTH-1:0]                id_q, id_d;
   logic                               pop;
   logic                               slot_free;
   logic                               load;
   logic                               out_valid;
   logic [ID_WIDTH+PKT_W-1:0]          pkt_in, pkt_out;

   // Depends only on registered state and the FIFO's registered flag, so no loop.
   assign bus.fifo_r_en = !rrst && !bus.fifo_empty && !bus.flush && (state_q != HOLD);
   assign pop           = bus.fifo_r_en;
   assign slot_free     = !out_valid || bus.out_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      id_d    = id_q;
      load    = 1'b0;
      if (pop) begin
         asm_d[cnt_q] = bus.fifo_data;
      end
      case (state_q)
         COLLECT: begin
            if (bus.flush) begin
               cnt_d = '0;
            end else if (pop) begin
               if (cnt_q == LAST_IDX) begin
                  cnt_d = '0;
                  if (slot_free) begin
                     load = 1'b1;
                  end else begin
                     state_d = HOLD;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (slot_free) begin
               load    = 1'b1;
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
      if (load) begin
         id_d = id_q + 1'b1;
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         state_q <= COLLECT;
         cnt_q   <= '0;
         asm_q   <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         id_q    <= id_d;
      end
   end

   // In HOLD nothing pops, so asm_d equals the stored complete packet.
   assign pkt_in = {id_q, asm_d};

   stream_out_reg #(
      .WIDTH (ID_WIDTH + PKT_W)
   ) u_out_reg (
      .clk     (rclk),
      .rst     (rrst),
      .load_i  (load),
      .ready_i (bus.out_ready),
      .data_i  (pkt_in),
      .valid_o (out_valid),
      .data_o  (pkt_out)
   );

   assign bus.out_valid = out_valid;
   assign bus.out_data  = pkt_out[PKT_W-1:0];
   assign bus.out_id    = pkt_out[ID_WIDTH+PKT_W-1:PKT_W];
   assign bus.busy      = (cnt_q != '0) || (state_q == HOLD);
endmodule

// File: tb/tb_fifo_ray_assembler.sv
// tb/tb_fifo_ray_assembler.sv - scoreboard bench for fifo_ray_assembler
module tb_fifo_ray_assembler;
   import rt_stream_pkg::*;

   localparam int DW    = 32;
   localparam int WORDS = 6;
   localparam int IDW   = 16;
   localparam int PW    = DW * WORDS;

   typedef struct packed {
      logic [PW-1:0]  data;
      logic [IDW-1:0] id;
   } pkt_t;

   logic       rclk = 1'b0;
   logic       rrst = 1'b1;
   int         pass_cnt = 0;
   int         total_cnt = 0;
   logic [DW-1:0] fifo_q[$];
   pkt_t       exp_q[$];
   pkt_t       got_q[$];
   logic [1:0] got2_q[$];
   int         exp_id = 0;
   bit         bubble_en = 1'b0;
   bit         bubble_phase = 1'b0;
   bit         last_popped = 1'b0;
   bit         last_empty = 1'b1;

   always #5 rclk = ~rclk;

   fifo_ray_assembler_if #(.DATA_WIDTH(DW), .WORDS(WORDS), .ID_WIDTH(IDW)) bus ();
   fifo_ray_assembler_if #(.DATA_WIDTH(DW), .WORDS(WORDS), .ID_WIDTH(2))   bus2 ();

   fifo_ray_assembler #(.DATA_WIDTH(DW), .WORDS(WORDS), .ID_WIDTH(IDW)) dut (
      .rclk (rclk),
      .rrst (rrst),
      .bus  (bus)
   );

   fifo_ray_assembler #(.DATA_WIDTH(DW), .WORDS(WORDS), .ID_WIDTH(2)) dut2 (
      .rclk (rclk),
      .rrst (rrst),
      .bus  (bus2)
   );

   assign bus2.fifo_empty = bus.fifo_empty;
   assign bus2.fifo_data  = bus.fifo_data;
   assign bus2.flush      = bus.flush;
   assign bus2.out_ready  = bus.out_ready;

   task automatic present_fifo();
      bus.fifo_empty = (fifo_q.size() == 0) || (bubble_en && bubble_phase);
      bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   task automatic cycle();
      present_fifo();
      #1;
      last_empty  = bus.fifo_empty;
      last_popped = bus.fifo_r_en && !bus.fifo_empty;
      if (bus.out_valid && bus.out_ready) begin
         got_q.push_back({bus.out_data, bus.out_id});
         got2_q.push_back(bus2.out_id);
      end
      @(posedge rclk);
      #1;
      if (last_popped) void'(fifo_q.pop_front());
      bubble_phase = !bubble_phase;
      present_fifo();
      #1;
   endtask

   task automatic push_raw(input logic [DW-1:0] base, input int n);
      for (int k = 0; k < n; k++) fifo_q.push_back(base + DW'(k));
   endtask

   task automatic push_packet(input logic [DW-1:0] base);
      pkt_t p;
      for (int k = 0; k < WORDS; k++) begin
         fifo_q.push_back(base + DW'(k));
         p.data[k*DW +: DW] = base + DW'(k);
      end
      p.id = IDW'(exp_id);
      exp_id++;
      exp_q.push_back(p);
   endtask

   task automatic test_reset();
      pkt_t g, e;
      rrst = 1'b1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      push_raw(32'h100, 12);
      repeat (2) cycle();
      total_cnt++;
      if (bus.fifo_r_en !== 1'b0) $display("FAIL reset_r_en: got %b want 0", bus.fifo_r_en); else pass_cnt++;
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else pass_cnt++;
      total_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
      rrst = 1'b0;
      repeat (8) cycle();
      total_cnt++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1)
         $display("FAIL pre_rst_state: got valid %b busy %b want 1 1", bus.out_valid, bus.busy);
      else pass_cnt++;
      #1 rrst = 1'b1;
      #1;
      total_cnt++;
      if (bus.out_valid !== 1'b0 || bus.out_id !== '0 || bus.fifo_r_en !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL async_rst: got valid %b id %0h r_en %b busy %b want 0 0 0 0",
                  bus.out_valid, bus.out_id, bus.fifo_r_en, bus.busy);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_data !== '0) $display("FAIL async_rst_data: got %h want 0", bus.out_data); else pass_cnt++;
      fifo_q.delete();
      got_q.delete();
      got2_q.delete();
      exp_q.delete();
      exp_id = 0;
      cycle();
      rrst = 1'b0;
      bus.out_ready = 1'b1;
      push_packet(32'h200);
      repeat (8) cycle();
      total_cnt++;
      if (got_q.size() != 1) $display("FAIL post_rst_count: got %0d want 1", got_q.size()); else pass_cnt++;
      while (got_q.size() != 0 && exp_q.size() != 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         void'(got2_q.pop_front());
         total_cnt++;
         if (g !== e) $display("FAIL post_rst_pkt: got id %0h data %h want id %0h data %h", g.id, g.data, e.id, e.data);
         else pass_cnt++;
      end
   endtask

   task automatic test_streaming();
      pkt_t g, e;
      int   pops;
      logic [IDW-1:0] base_id;
      base_id = IDW'(exp_id);
      bus.out_ready = 1'b1;
      push_packet(32'h10);
      push_packet(32'h16);
      pops = 0;
      for (int c = 0; c < 6; c++) begin
         cycle();
         if (last_popped) pops++;
         if (c == 4) begin
            total_cnt++;
            if (bus.out_valid !== 1'b0) $display("FAIL stream_early_valid: got %b want 0", bus.out_valid); else pass_cnt++;
         end
      end
      total_cnt++;
      if (pops != 6) $display("FAIL stream_pops0: got %0d want 6", pops); else pass_cnt++;
      total_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== base_id)
         $display("FAIL stream_first: got valid %b id %0h want 1 %0h", bus.out_valid, bus.out_id, base_id);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_data[RAY_OX*DW +: DW] !== 32'h10 || bus.out_data[RAY_DZ*DW +: DW] !== 32'h15)
         $display("FAIL stream_words: got ox %h dz %h want 10 15",
                  bus.out_data[RAY_OX*DW +: DW], bus.out_data[RAY_DZ*DW +: DW]);
      else pass_cnt++;
      pops = 0;
      repeat (6) begin
         cycle();
         if (last_popped) pops++;
      end
      total_cnt++;
      if (pops != 6) $display("FAIL stream_pops1: got %0d want 6", pops); else pass_cnt++;
      total_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== base_id + 1'b1)
         $display("FAIL stream_second: got valid %b id %0h want 1 %0h", bus.out_valid, bus.out_id, base_id + 1'b1);
      else pass_cnt++;
      cycle();
      total_cnt++;
      if (got_q.size() != 2) $display("FAIL stream_count: got %0d want 2", got_q.size()); else pass_cnt++;
      while (got_q.size() != 0 && exp_q.size() != 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         void'(got2_q.pop_front());
         total_cnt++;
         if (g !== e) $display("FAIL stream_pkt: got id %0h data %h want id %0h data %h", g.id, g.data, e.id, e.data);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      pkt_t g, e;
      int   pops;
      logic [IDW-1:0] base_id;
      base_id = IDW'(exp_id);
      bus.out_ready = 1'b0;
      push_packet(32'h30);
      push_packet(32'h36);
      push_packet(32'h3c);
      pops = 0;
      repeat (12) begin
         cycle();
         if (last_popped) pops++;
      end
      total_cnt++;
      if (pops != 12) $display("FAIL bp_pops: got %0d want 12", pops); else pass_cnt++;
      total_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== base_id || bus.busy !== 1'b1 || bus.fifo_r_en !== 1'b0)
         $display("FAIL bp_hold: got valid %b id %0h busy %b r_en %b want 1 %0h 1 0",
                  bus.out_valid, bus.out_id, bus.busy, bus.fifo_r_en, base_id);
      else pass_cnt++;
      bus.out_ready = 1'b1;
      cycle();
      total_cnt++;
      if (last_popped !== 1'b0) $display("FAIL bp_exit_pop: got %b want 0", last_popped); else pass_cnt++;
      total_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== base_id + 1'b1 || bus.fifo_r_en !== 1'b1)
         $display("FAIL bp_exit: got valid %b id %0h r_en %b want 1 %0h 1",
                  bus.out_valid, bus.out_id, bus.fifo_r_en, base_id + 1'b1);
      else pass_cnt++;
      cycle();
      total_cnt++;
      if (last_popped !== 1'b1) $display("FAIL bp_resume: got %b want 1", last_popped); else pass_cnt++;
      repeat (6) cycle();
      total_cnt++;
      if (got_q.size() != 3) $display("FAIL bp_count: got %0d want 3", got_q.size()); else pass_cnt++;
      while (got_q.size() != 0 && exp_q.size() != 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         void'(got2_q.pop_front());
         total_cnt++;
         if (g !== e) $display("FAIL bp_pkt: got id %0h data %h want id %0h data %h", g.id, g.data, e.id, e.data);
         else pass_cnt++;
      end
   endtask

   task automatic test_bubbles();
      pkt_t g, e;
      int   empty_pops;
      int   pops;
      bus.out_ready = 1'b1;
      push_packet(32'h40);
      bubble_en = 1'b1;
      bubble_phase = 1'b1;
      empty_pops = 0;
      pops = 0;
      for (int c = 0; c < 12; c++) begin
         cycle();
         if (last_popped) pops++;
         if (last_popped && last_empty) empty_pops++;
         if (c == 10) begin
            total_cnt++;
            if (bus.out_valid !== 1'b0) $display("FAIL bubble_early: got %b want 0", bus.out_valid); else pass_cnt++;
         end
      end
      total_cnt++;
      if (empty_pops != 0 || pops != 6) $display("FAIL bubble_pops: got %0d/%0d want 0/6", empty_pops, pops); else pass_cnt++;
      total_cnt++;
      if (bus.out_valid !== 1'b1) $display("FAIL bubble_done: got %b want 1", bus.out_valid); else pass_cnt++;
      bubble_en = 1'b0;
      cycle();
      total_cnt++;
      if (got_q.size() != 1) $display("FAIL bubble_count: got %0d want 1", got_q.size()); else pass_cnt++;
      while (got_q.size() != 0 && exp_q.size() != 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         void'(got2_q.pop_front());
         total_cnt++;
         if (g !== e) $display("FAIL bubble_pkt: got id %0h data %h want id %0h data %h", g.id, g.data, e.id, e.data);
         else pass_cnt++;
      end
   endtask

   task automatic test_flush();
      pkt_t g, e;
      bus.out_ready = 1'b1;
      push_raw(32'ha0, 3);
      push_packet(32'h20);
      repeat (3) cycle();
      total_cnt++;
      if (bus.busy !== 1'b1) $display("FAIL flush_partial: got busy %b want 1", bus.busy); else pass_cnt++;
      bus.flush = 1'b1;
      cycle();
      bus.flush = 1'b0;
      total_cnt++;
      if (last_popped !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL flush_drop: got pop %b busy %b want 0 0", last_popped, bus.busy);
      else pass_cnt++;
      repeat (7) cycle();
      bus.out_ready = 1'b0;
      push_packet(32'h50);
      push_packet(32'h56);
      repeat (12) cycle();
      bus.flush = 1'b1;
      cycle();
      bus.flush = 1'b0;
      total_cnt++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1)
         $display("FAIL flush_hold: got busy %b valid %b want 1 1", bus.busy, bus.out_valid);
      else pass_cnt++;
      bus.out_ready = 1'b1;
      repeat (3) cycle();
      total_cnt++;
      if (got_q.size() != 3) $display("FAIL flush_count: got %0d want 3", got_q.size()); else pass_cnt++;
      while (got_q.size() != 0 && exp_q.size() != 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         void'(got2_q.pop_front());
         total_cnt++;
         if (g !== e) $display("FAIL flush_pkt: got id %0h data %h want id %0h data %h", g.id, g.data, e.id, e.data);
         else pass_cnt++;
      end
   endtask

   task automatic test_id_wrap();
      pkt_t g, e;
      logic [1:0] g2;
      logic [1:0] wrap_ids [5];
      int   n;
      wrap_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rrst = 1'b1;
      cycle();
      rrst = 1'b0;
      fifo_q.delete();
      got_q.delete();
      got2_q.delete();
      exp_q.delete();
      exp_id = 0;
      bus.out_ready = 1'b1;
      for (int p = 0; p < 5; p++) push_packet(32'h60 + DW'(p * WORDS));
      repeat (31) cycle();
      total_cnt++;
      if (got_q.size() != 5) $display("FAIL wrap_count: got %0d want 5", got_q.size()); else pass_cnt++;
      n = 0;
      while (got_q.size() != 0 && exp_q.size() != 0 && n < 5) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         g2 = got2_q.pop_front();
         total_cnt++;
         if (g !== e) $display("FAIL wrap_pkt: got id %0h data %h want id %0h data %h", g.id, g.data, e.id, e.data);
         else pass_cnt++;
         total_cnt++;
         if (g2 !== wrap_ids[n]) $display("FAIL wrap_id2 #%0d: got %0d want %0d", n, g2, wrap_ids[n]);
         else pass_cnt++;
         n++;
      end
   endtask

   initial begin
      bus.flush      = 1'b0;
      bus.out_ready  = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.fifo_data  = '0;
      test_reset();
      test_streaming();
      test_back_to_back();
      test_bubbles();
      test_flush();
      test_id_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/fifo_ray_assembler.md
# fifo_ray_assembler

Read-side consumer of the asynchronous ray FIFO. It pops fixed-width words from the FIFO read port and assembles every WORDS consecutive words into one ray packet: origin x/y/z, then direction x/y/z. Each packet is tagged with a sequence ID and presented on a valid/ready stream to the intersection pipeline. The block runs entirely in the FIFO read clock domain.

## Interface
- DATA_WIDTH, 32, width of one FIFO word
- WORDS, 6, words per ray packet (must be ≥ 2)
- ID_WIDTH, 16, width of the packet sequence counter

- rclk  in  1  read-domain clock; one clock, all logic on its rising edge
- rrst  in  1  reset, asynchronous, active-high
- fifo_empty  in  1  FIFO empty flag (registered inside the FIFO)
- fifo_data  in  DATA_WIDTH  FIFO head word (fall-through: valid whenever !fifo_empty)
- fifo_r_en  out  1  pop request to the FIFO
- flush  in  1  synchronous discard of the partially assembled packet
- out_valid  out  1  packet available
- out_ready  in  1  downstream accepts the packet
- out_data  out  WORDS*DATA_WIDTH  packet; word k at [k*DATA_WIDTH +: DATA_WIDTH]
- out_id  out  ID_WIDTH  sequence number of the packet
- busy  out  1  partial packet held (word count ≠ 0) or state HOLD

## Operation
- Pop occurs when fifo_r_en && !fifo_empty. fifo_data is captured at that rclk edge into assembly slot `cnt`, and `cnt` increments.
- fifo_r_en = !rrst && !fifo_empty && !flush && state != HOLD. It is combinational from registered state and the registered FIFO flag, so there is no loop.
- Slot free ≡ !out_valid || out_ready.
- States:
  - COLLECT (reset state): pop words; cnt runs 0..WORDS-1. On the pop of word WORDS-1:
    - if slot free: load out_data with the assembled words plus this word, set out_valid, cnt→0, stay in COLLECT.
    - else: store the complete packet in the assembly register and go to HOLD.
  - HOLD: no pops. When slot free, load out_data from the assembly register, set out_valid, cnt→0, go to COLLECT. Popping resumes the next cycle.
- out_valid clears on out_valid && out_ready unless a new load happens the same cycle; in that case it stays high with the new data.
- out_id: counter starts at 0. It is copied to out_id at each load, then incremented; it wraps modulo 2^ID_WIDTH.
- flush in COLLECT: cnt→0, no pop that cycle, words already popped are dropped. flush in HOLD is ignored. flush never affects the output register or the ID counter.
- Simultaneous flush and final word: flush wins and nothing is popped.
- Async rrst at any time: cnt 0, state COLLECT, out_valid 0, out_data 0, out_id 0, ID counter 0, busy 0, fifo_r_en 0. A packet in flight is lost.

## Timing
- Latency: out_valid rises the rclk edge that pops the last word, i.e. it is visible the cycle after that pop.
- Sustained throughput with out_ready=1 and a non-empty FIFO: one packet per WORDS cycles, with no bubbles between packets.
- After out_valid rises, out_data and out_id stay stable until accepted.
- HOLD exit to the first new pop takes 1 cycle.
- Reset values: all outputs 0, including fifo_r_en while rrst is high.

## Structure
- Shared package rt_stream_pkg holds:
  - the state enum (COLLECT, HOLD)
  - word-index localparams: RAY_OX=0, RAY_OY=1, RAY_OZ=2, RAY_DX=3, RAY_DY=4, RAY_DZ=5
- One sub-module, stream_out_reg: a single valid/ready output register with load, accept, and async reset. The FSM, cnt, assembly register and ID counter stay in the top level.

## Test plan
- Reset: assert rrst mid-run → out_valid, out_id, fifo_r_en and busy read 0 in the same cycle. After release, the first packet has out_id=0.
- Streaming: FIFO supplies 0x10..0x15, out_ready=1 → fifo_r_en high for 6 cycles; out_valid asserts one cycle after the 6th pop with out_data word0=0x10 … word5=0x15 and out_id=0. The next 6 words produce out_id=1 with no gap.
- Back-pressure: out_ready=0, 12 words available → packet 0 is held on the output, packet 1 is assembled, state HOLD, fifo_r_en=0 after the 12th pop. Raise out_ready → id 0 is accepted, id 1 appears the next cycle, and popping resumes one cycle later.
- Bubbles: fifo_empty alternates 1/0 every cycle → no pop while empty, and the packet completes after 12 cycles with the correct word order.
- Flush: flush pulses after 3 words popped → busy=0. The next 6 words (0x20..0x25) form a packet containing only 0x20..0x25. flush pulsed while in HOLD → the held packet is still delivered intact.
- ID wrap: ID_WIDTH=2, 5 packets → out_id sequence 0,1,2,3,0.
